// File: rtl/seg7_pkg.sv
// Shared types, ASCII constants, glyph table and byte helpers for the
// UART-driven 4-digit seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_e;

  typedef enum logic [1:0] {
    CLS_HEX = 2'd0,
    CLS_DOT = 2'd1,
    CLS_CLR = 2'd2,
    CLS_ERR = 2'd3
  } byte_class_e;

  typedef struct packed {
    logic [3:0] val;
    logic       blank;
    logic       dp;
  } digit_t;

  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  localparam digit_t DIGIT_BLANK = '{val: 4'h0, blank: 1'b1, dp: 1'b0};

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; b and d are lowercase.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic byte_class_e classify(input logic [7:0] b);
    if (b inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]}) return CLS_HEX;
    if (b == ASCII_DOT) return CLS_DOT;
    if (b == ASCII_ESC) return CLS_CLR;
    return CLS_ERR;
  endfunction

  // Letters in either case carry (value - 9) in their low nibble.
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    if (b[6]) return b[3:0] + 4'd9;
    return b[3:0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex-to-seven-segment decoder, active-high, with blanking.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'd0;
    if (!i_blank) o_seg = GLYPH[i_val];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// UART byte stream -> 4-digit shift buffer -> multiplexed seven-segment scan
// with inter-digit blanking and registered, polarity-configurable outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int DIGIT_HZ   = 1_000,
  parameter int BLANK_CYC  = 270,
  parameter int ACTIVE_LOW = 1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       byte_err
);

  localparam int   PERIOD = CLK_HZ / DIGIT_HZ;
  localparam int   CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic POL    = (ACTIVE_LOW != 0);

  logic [7:0]        r_data_p0;
  logic              r_vld_p0;
  byte_class_e       w_cls_p1;
  digit_t [3:0]      r_buf;
  logic              r_err_p1;

  scan_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic              w_wrap;

  digit_t            w_cur;
  logic [6:0]        w_glyph;
  logic [6:0]        w_seg_nxt;
  logic [3:0]        w_an_nxt;
  logic              w_dp_nxt;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;
  logic              r_dp;

  // Stage p0: capture the received byte
  always_ff @(posedge clk) begin
    r_data_p0 <= rx_data;
    if (reset) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= rx_valid;
  end

  // Stage p1: classify and apply to the digit buffer
  assign w_cls_p1 = classify(r_data_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf    <= {4{DIGIT_BLANK}};
      r_err_p1 <= 1'b0;
    end else begin
      r_err_p1 <= r_vld_p0 && (w_cls_p1 == CLS_ERR);
      if (r_vld_p0) begin
        case (w_cls_p1)
          CLS_HEX: r_buf <= {r_buf[2:0],
                             digit_t'{val: hex_nibble(r_data_p0), blank: 1'b0, dp: 1'b0}};
          CLS_DOT: r_buf[0].dp <= 1'b1;
          CLS_CLR: r_buf <= {4{DIGIT_BLANK}};
          default: ;
        endcase
      end
    end
  end

  assign byte_err = r_err_p1;

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Scan FSM: next state; blanking occupies the first BLANK_CYC counts of each dwell
  always_comb begin
    w_wrap      = (r_cnt == CNT_W'(PERIOD - 1));
    w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = w_wrap ? r_idx + 2'd1 : r_idx;
    w_state_nxt = (w_cnt_nxt < CNT_W'(BLANK_CYC)) ? SCAN_BLANK : SCAN_ON;
  end

  assign w_cur = r_buf[r_idx];

  seg7_decode u_decode (
    .i_val   (w_cur.val),
    .i_blank (w_cur.blank),
    .o_seg   (w_glyph)
  );

  // Scan FSM: outputs, active-high before polarity is applied
  always_comb begin
    w_an_nxt  = 4'b0000;
    w_seg_nxt = 7'd0;
    w_dp_nxt  = 1'b0;
    if (r_state == SCAN_ON) begin
      w_an_nxt  = 4'b0001 << r_idx;
      w_seg_nxt = w_glyph;
      w_dp_nxt  = w_cur.dp && !w_cur.blank;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= {7{POL}};
      r_an  <= {4{POL}};
      r_dp  <= POL;
    end else begin
      r_seg <= w_seg_nxt ^ {7{POL}};
      r_an  <= w_an_nxt ^ {4{POL}};
      r_dp  <= w_dp_nxt ^ POL;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule
